// File: rtl/uart_tx_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_pkg
// Shared definitions for the UART transmit scheduler:
//   - state_t          : 2-bit FSM encoding (IDLE=00, ARM=01, SENDING=11, RELEASE=10)
//   - clock/baud constants from which the default SENDING timeout is chosen
//   - next_idx()       : wrap-around increment of a requester index
// -----------------------------------------------------------------------------
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARM     = 2'b01,
    ST_SENDING = 2'b11,
    ST_RELEASE = 2'b10
  } state_t;

  localparam int unsigned CLK_HZ     = 100_000_000;
  localparam int unsigned BAUD       = 9600;
  localparam int unsigned FRAME_BITS = 10;

  // Cycles for one frame at the default baud; the timeout leaves a wide
  // margin above it so only a stuck transmitter trips the abort.
  localparam int unsigned FRAME_CYCLES            = (CLK_HZ / BAUD) * FRAME_BITS;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 2_000_000;

  // (idx + 1) mod n for a 3-bit requester index.
  function automatic logic [2:0] next_idx(input logic [2:0] idx, input int n);
    if (int'({29'd0, idx}) >= n - 1) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin picker: returns the first set request bit found
// searching upward from the pointer, wrapping at NUM_REQ.
// Ports:
//   i_req   [NUM_REQ-1:0] : request levels
//   i_ptr   [2:0]         : priority pointer (0..NUM_REQ-1)
//   o_idx   [2:0]         : winning requester index (0 when none)
//   o_valid               : at least one request is set
// -----------------------------------------------------------------------------
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [2:0]         i_ptr,
  output logic [2:0]         o_idx,
  output logic               o_valid
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;

  // Rotate so bit k of w_rot is requester (ptr + k) mod NUM_REQ.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  always_comb begin
    logic [3:0] w_sum;
    o_idx   = 3'd0;
    o_valid = 1'b0;
    w_sum   = 4'd0;
    // Walk downward so the smallest offset from the pointer wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = {1'b0, i_ptr} + 4'(k);
        if (w_sum >= 4'(NUM_REQ)) w_sum = w_sum - 4'(NUM_REQ);
        o_idx   = w_sum[2:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART_byte transmitter among NUM_REQ byte producers. Arbitrates
// round-robin, latches the winner's byte, runs the start/BRG/done handshake
// and returns a one-cycle ack (or err on timeout) to the requester.
// Ports:
//   i_clk, i_rst         : clock, asynchronous active-high reset
//   i_req   [N-1:0]      : per-requester request level
//   i_req_data [8N-1:0]  : byte of requester i at [8i+7:8i]
//   o_ack   [N-1:0]      : one-cycle pulse, byte fully sent
//   o_err   [N-1:0]      : one-cycle pulse, transfer aborted by timeout
//   o_busy               : high in every state except IDLE
//   o_grant_id [2:0]     : current / last granted requester
//   o_uart_data [7:0]    : latched byte to UART_byte
//   o_uart_start         : start request to UART_byte
//   i_uart_brg_set       : BRG tick from UART_byte
//   i_uart_done          : byte-complete level from UART_byte
// -----------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [NUM_REQ-1:0]   o_err,
  output logic                 o_busy,
  output logic [2:0]           o_grant_id,
  output logic [7:0]           o_uart_data,
  output logic                 o_uart_start,
  input  logic                 i_uart_brg_set,
  input  logic                 i_uart_done
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0] w_pick_idx;
  logic       w_pick_vld;
  logic [7:0] w_sel_byte;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  always_comb begin
    w_sel_byte = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_idx == 3'(i)) w_sel_byte = i_req_data[8*i +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= 3'd0;
      r_cnt        <= '0;
      o_ack        <= '0;
      o_err        <= '0;
      o_busy       <= 1'b0;
      o_grant_id   <= 3'd0;
      o_uart_data  <= 8'd0;
      o_uart_start <= 1'b0;
    end else begin
      o_ack <= '0;
      o_err <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            o_grant_id   <= w_pick_idx;
            o_uart_data  <= w_sel_byte;
            o_uart_start <= 1'b1;
            o_busy       <= 1'b1;
            r_state      <= ST_ARM;
          end
        end
        // Hold start until UART_byte's baud tick has been seen.
        ST_ARM: begin
          if (i_uart_brg_set) begin
            o_uart_start <= 1'b0;
            r_cnt        <= '0;
            r_state      <= ST_SENDING;
          end
        end
        // Done takes precedence over a timeout landing on the same edge.
        ST_SENDING: begin
          if (i_uart_done) begin
            o_ack   <= ONE_HOT0 << o_grant_id;
            r_ptr   <= next_idx(o_grant_id, NUM_REQ);
            r_state <= ST_RELEASE;
          end else if (r_cnt == CNT_LAST) begin
            o_err   <= ONE_HOT0 << o_grant_id;
            r_ptr   <= next_idx(o_grant_id, NUM_REQ);
            r_state <= ST_RELEASE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // Wait out a level-held done so one byte yields exactly one ack.
        ST_RELEASE: begin
          if (!i_uart_done) begin
            o_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          o_busy       <= 1'b0;
          o_uart_start <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int TMO  = 100;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [31:0]     req_data = '0;
  logic [NREQ-1:0] ack, err;
  logic            busy;
  logic [2:0]      grant;
  logic [7:0]      udata;
  logic            ustart;
  logic            brg = 1'b0;
  logic            done = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_scheduler #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .i_req_data     (req_data),
    .o_ack          (ack),
    .o_err          (err),
    .o_busy         (busy),
    .o_grant_id     (grant),
    .o_uart_data    (udata),
    .o_uart_start   (ustart),
    .i_uart_brg_set (brg),
    .i_uart_done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transfer from IDLE with the winner's request already present.
  task automatic do_xfer(input logic [2:0] id, input logic [7:0] dat, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    step();
    chk({tag, " grant"}, 32'(grant), 32'(id));
    chk({tag, " data"},  32'(udata), 32'(dat));
    chk({tag, " start"}, 32'(ustart), 32'd1);
    brg = 1'b1; step(); brg = 1'b0;
    chk({tag, " start_drop"}, 32'(ustart), 32'd0);
    done = 1'b1; step(); done = 1'b0;
    chk({tag, " ack"}, 32'(ack), 32'(oh));
    chk({tag, " err"}, 32'(err), 32'd0);
    step();
    chk({tag, " ack_clr"}, 32'(ack), 32'd0);
    chk({tag, " idle"},    32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; brg = 1'b0; done = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int acks;

    // ---------------- reset values
    do_reset();
    chk("rst busy",  32'(busy),   32'd0);
    chk("rst grant", 32'(grant),  32'd0);
    chk("rst data",  32'(udata),  32'd0);
    chk("rst start", 32'(ustart), 32'd0);
    chk("rst ack",   32'(ack),    32'd0);
    chk("rst err",   32'(err),    32'd0);

    // ---------------- single request, start held until BRG tick
    req_data = 32'h0000_4100;
    req = 4'b0010;
    step();
    chk("single grant", 32'(grant), 32'd1);
    chk("single data",  32'(udata), 32'h41);
    chk("single start", 32'(ustart), 32'd1);
    chk("single busy",  32'(busy), 32'd1);
    req = '0;
    step(); step(); step();
    chk("single start_hold", 32'(ustart), 32'd1);
    brg = 1'b1; step(); brg = 1'b0;
    chk("single start_drop", 32'(ustart), 32'd0);
    step();
    chk("single no_early_ack", 32'(ack), 32'd0);
    done = 1'b1; step(); done = 1'b0;
    chk("single ack", 32'(ack), 32'b0010);
    step();
    chk("single ack_pulse", 32'(ack), 32'd0);
    chk("single busy_clr", 32'(busy), 32'd0);

    // ---------------- simultaneous requests after reset: 0,1,2,3
    do_reset();
    req_data = 32'h3332_3130;
    req = 4'b1111;
    do_xfer(3'd0, 8'h30, "sim0"); req[0] = 1'b0;
    do_xfer(3'd1, 8'h31, "sim1"); req[1] = 1'b0;
    do_xfer(3'd2, 8'h32, "sim2"); req[2] = 1'b0;
    do_xfer(3'd3, 8'h33, "sim3"); req[3] = 1'b0;
    step();
    chk("sim idle", 32'(busy), 32'd0);

    // ---------------- rotation with done held high as a level
    req_data = 32'hD3C2_B1A0;
    req = 4'b0100;
    step();
    chk("rot grant2", 32'(grant), 32'd2);
    req = 4'b1001;
    brg = 1'b1; step(); brg = 1'b0;
    done = 1'b1;
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (ack != 4'b0000) begin
        chk("rot ack_bits", 32'(ack), 32'b0100);
        acks++;
      end
    end
    chk("rot one_ack", 32'(acks), 32'd1);
    chk("rot held_busy", 32'(busy), 32'd1);
    done = 1'b0;
    step();
    chk("rot released", 32'(busy), 32'd0);
    do_xfer(3'd3, 8'hD3, "rot3"); req[3] = 1'b0;
    do_xfer(3'd0, 8'hA0, "rot0"); req[0] = 1'b0;

    // ---------------- timeout, then next requester served
    do_reset();
    req_data = 32'h0000_6655;
    req = 4'b0011;
    step();
    chk("tmo grant0", 32'(grant), 32'd0);
    brg = 1'b1; step(); brg = 1'b0;
    for (int i = 0; i < TMO - 1; i++) step();
    chk("tmo early_err", 32'(err), 32'd0);
    step();
    chk("tmo err", 32'(err), 32'b0001);
    chk("tmo no_ack", 32'(ack), 32'd0);
    req[0] = 1'b0;
    step();
    chk("tmo err_pulse", 32'(err), 32'd0);
    do_xfer(3'd1, 8'h66, "tmo next"); req[1] = 1'b0;

    // ---------------- done coincides with timeout: ack wins
    req_data = 32'h0077_0000;
    req = 4'b0100;
    step();
    req = '0;
    brg = 1'b1; step(); brg = 1'b0;
    for (int i = 0; i < TMO - 1; i++) step();
    done = 1'b1; step(); done = 1'b0;
    chk("tie ack", 32'(ack), 32'b0100);
    chk("tie err", 32'(err), 32'd0);
    step();

    // ---------------- withdrawal of requester 1 while busy with 0
    do_reset();
    req_data = 32'h0000_2211;
    req = 4'b0001;
    step();
    chk("wd grant0", 32'(grant), 32'd0);
    req = 4'b0011; step();
    req = 4'b0000;
    brg = 1'b1; step(); brg = 1'b0;
    done = 1'b1; step(); done = 1'b0;
    chk("wd ack0", 32'(ack), 32'b0001);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack != 4'b0000) acks++;
    end
    chk("wd no_ack1", 32'(acks), 32'd0);
    chk("wd grant_kept", 32'(grant), 32'd0);
    chk("wd idle", 32'(busy), 32'd0);

    // ---------------- reset in SENDING, then pointer back at 0
    req_data = 32'h0044_3300;
    req = 4'b0100;
    step();
    chk("mid grant2", 32'(grant), 32'd2);
    req = '0;
    brg = 1'b1; step(); brg = 1'b0;
    step();
    rst = 1'b1; #2;
    chk("mid busy",  32'(busy),   32'd0);
    chk("mid start", 32'(ustart), 32'd0);
    chk("mid ack",   32'(ack),    32'd0);
    chk("mid err",   32'(err),    32'd0);
    step();
    rst = 1'b0;
    req = 4'b0110;
    step();
    chk("mid regrant", 32'(grant), 32'd1);
    chk("mid data",    32'(udata), 32'h33);
    chk("arm start",   32'(ustart), 32'd1);
    // Reset in ARM drops start without waiting for a clock edge.
    rst = 1'b1; #2;
    chk("arm async_start", 32'(ustart), 32'd0);
    step();
    rst = 1'b0; req = '0;
    step();
    chk("end idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
